if_fetch_queue: RTL and testbench

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/if_fetch_queue.sv | 91 +++++++++
 tb/tb_if_fetch_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: credit-limited in-order instruction fetch queue with redirect flush
//   clk, rst_n                  : clock, asynchronous active-low reset
//   imem_req_valid/ready, addr  : fetch request channel to instruction memory
//   imem_resp_valid/data        : in-order response channel from instruction memory
//   redirect_valid/pc           : control-flow redirect from a later stage
//   inst_valid/ready, inst/pc   : instruction channel to the decoder
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);
  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  logic [31:0] pend_q [4];
  logic [63:0] fifo_q [4];
  logic [1:0]  pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
  logic [1:0]  fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [2:0]  out_q, out_d, buf_q, buf_d, stale_q, stale_d;
  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        run_q;
  logic        req_fire, resp_fire, keep, pop;
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction
  assign imem_addr      = pc_q;
  // outstanding (stale included) plus buffered never exceeds DEPTH, so a kept response always has room
  assign imem_req_valid = run_q & ~redirect_valid & (out_q + buf_q < 3'(DEPTH));
  assign inst_valid     = buf_q != 3'd0;
  assign inst           = fifo_q[fifo_rd_q][31:0];
  assign inst_pc        = fifo_q[fifo_rd_q][63:32];
  assign req_fire       = imem_req_valid & imem_req_ready;
  // a response with nothing outstanding is a protocol error and is ignored
  assign resp_fire      = imem_resp_valid & (out_q != 3'd0);
  // stale responses are always the oldest, so FLUSH drops every response until stale_cnt drains
  assign keep           = resp_fire & ~redirect_valid & (state_q == FETCH);
  assign pop            = inst_valid & inst_ready & ~redirect_valid;
  always_comb begin
    out_d     = out_q + 3'(req_fire) - 3'(resp_fire);
    buf_d     = redirect_valid ? 3'd0 : buf_q + 3'(keep) - 3'(pop);
    stale_d   = redirect_valid ? out_q - 3'(resp_fire) : stale_q - 3'(resp_fire & (state_q == FLUSH));
    state_d   = (stale_d != 3'd0) ? FLUSH : FETCH;
    pc_d      = redirect_valid ? (redirect_pc & ~32'd3) : req_fire ? pc_q + 32'd4 : pc_q;
    pend_rd_d = resp_fire ? nxt(pend_rd_q) : pend_rd_q;
    pend_wr_d = req_fire ? nxt(pend_wr_q) : pend_wr_q;
    fifo_rd_d = redirect_valid ? 2'd0 : pop ? nxt(fifo_rd_q) : fifo_rd_q;
    fifo_wr_d = redirect_valid ? 2'd0 : keep ? nxt(fifo_wr_q) : fifo_wr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC & ~32'd3;
      run_q     <= 1'b0;
      out_q     <= 3'd0;
      buf_q     <= 3'd0;
      stale_q   <= 3'd0;
      state_q   <= FETCH;
      pend_rd_q <= 2'd0;
      pend_wr_q <= 2'd0;
      fifo_rd_q <= 2'd0;
      fifo_wr_q <= 2'd0;
    end else begin
      pc_q      <= pc_d;
      run_q     <= 1'b1;
      out_q     <= out_d;
      buf_q     <= buf_d;
      stale_q   <= stale_d;
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      pend_wr_q <= pend_wr_d;
      fifo_rd_q <= fifo_rd_d;
      fifo_wr_q <= fifo_wr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (req_fire) pend_q[pend_wr_q] <= pc_q;
    if (keep) fifo_q[fifo_wr_q] <= {pend_q[pend_rd_q], imem_resp_data};
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: randomized and directed checking of if_fetch_queue against a queue-based model
module tb_if_fetch_queue;
  localparam int DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  typedef struct {logic [31:0] addr; int due; bit stale;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  int checks = 0, failures = 0;
  pend_t mq[$];
  ent_t fifo[$];
  logic [31:0] m_pc = RESET_PC;
  bit m_run = 0;
  bit e_req_valid, e_inst_valid;
  int cyc = 0, rel_cyc = 0, first_iv = -1;
  logic [31:0] acc_log[$], out_log[$];
  int k_ready, k_iready, k_redir, k_lat, k_resp, k_spur;
  bit f_redir = 0, f_rel = 0;
  logic [31:0] f_rpc = 32'd0;
  if_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic knobs(input int r, input int ir, input int rd, input int lat, input int rs, input int sp);
    k_ready = r; k_iready = ir; k_redir = rd; k_lat = lat; k_resp = rs; k_spur = sp;
  endtask
  task automatic clear_logs();
    acc_log.delete(); out_log.delete(); first_iv = -1;
  endtask
  task automatic compare();
    e_req_valid = rst_n && m_run && !redirect_valid && (mq.size() + fifo.size() < DEPTH);
    e_inst_valid = rst_n && fifo.size() > 0;
    chk("req_valid", 32'(imem_req_valid), 32'(e_req_valid));
    if (e_req_valid) chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(e_inst_valid));
    if (e_inst_valid) begin
      chk("inst", inst, fifo[0].data);
      chk("inst_pc", inst_pc, fifo[0].pc);
    end
    if (inst_valid === 1'b1 && first_iv < 0) first_iv = cyc - rel_cyc;
    if (inst_valid === 1'b1 && inst_ready && !redirect_valid) out_log.push_back(inst_pc);
  endtask
  task automatic update();
    bit resp, req, pop;
    pend_t r;
    resp = imem_resp_valid && mq.size() > 0;
    req = e_req_valid && imem_req_ready;
    pop = e_inst_valid && inst_ready;
    if (resp) begin
      r = mq.pop_front();
      if (!redirect_valid && !r.stale) fifo.push_back('{r.addr, data_of(r.addr)});
    end
    if (redirect_valid) begin
      fifo.delete();
      foreach (mq[i]) mq[i].stale = 1;
      m_pc = redirect_pc & ~32'd3;
    end else begin
      if (pop) fifo.delete(0);
      if (req) begin
        mq.push_back('{m_pc, cyc + 1 + int'($urandom_range(k_lat, 0)), 1'b0});
        acc_log.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    m_run = 1;
  endtask
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (f_rel) begin rst_n = 1'b1; rel_cyc = cyc; f_rel = 0; end
    imem_req_ready = $urandom_range(99, 0) < k_ready;
    inst_ready = $urandom_range(99, 0) < k_iready;
    redirect_valid = f_redir ? 1'b1 : ($urandom_range(999, 0) < k_redir);
    redirect_pc = f_redir ? f_rpc : $urandom;
    f_redir = 0;
    if (mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99, 0) < k_resp) begin
      imem_resp_valid = 1'b1; imem_resp_data = data_of(mq[0].addr);
    end else if (mq.size() == 0 && $urandom_range(99, 0) < k_spur) begin
      imem_resp_valid = 1'b1; imem_resp_data = $urandom;
    end else begin
      imem_resp_valid = 1'b0; imem_resp_data = $urandom;
    end
    #1 compare();
    @(posedge clk);
    if (rst_n) update();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; redirect_valid = 1'b0; imem_resp_valid = 1'b0; inst_ready = 1'b0; imem_req_ready = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    mq.delete(); fifo.delete(); m_pc = RESET_PC; m_run = 0;
    @(posedge clk);
    f_rel = 1;
  endtask
  initial begin
    knobs(100, 100, 0, 0, 100, 0);
    do_reset();
    clear_logs();
    repeat (10) cycle();
    #1;
    chk("A_addr0", qget(acc_log, 0), 32'h0);
    chk("A_addr1", qget(acc_log, 1), 32'h4);
    chk("A_addr2", qget(acc_log, 2), 32'h8);
    chk("A_first_inst_valid", 32'(first_iv), 32'd3);
    chk("A_pc0", qget(out_log, 0), 32'h0);
    chk("A_pc1", qget(out_log, 1), 32'h4);
    chk("A_pc2", qget(out_log, 2), 32'h8);
    knobs(100, 0, 0, 0, 100, 0);
    do_reset();
    clear_logs();
    repeat (10) cycle();
    #1;
    chk("B_nacc", 32'(acc_log.size()), 32'd2);
    chk("B_addr1", qget(acc_log, 1), 32'h4);
    chk("B_req_valid", 32'(imem_req_valid), 32'd0);
    chk("B_inst", inst, 32'h1234_5678);
    chk("B_inst_pc", inst_pc, 32'h0);
    knobs(100, 100, 0, 0, 100, 0);
    repeat (6) cycle();
    #1;
    chk("B_out0", qget(out_log, 0), 32'h0);
    chk("B_out1", qget(out_log, 1), 32'h4);
    knobs(100, 0, 0, 0, 0, 0);
    do_reset();
    repeat (4) cycle();
    clear_logs();
    f_redir = 1; f_rpc = 32'h0000_1002;
    cycle();
    knobs(100, 100, 0, 0, 100, 0);
    repeat (10) cycle();
    #1;
    chk("C_addr", qget(acc_log, 0), 32'h0000_1000);
    chk("C_pc0", qget(out_log, 0), 32'h0000_1000);
    chk("C_pc1", qget(out_log, 1), 32'h0000_1004);
    clear_logs();
    f_redir = 1; f_rpc = 32'hFFFF_FFFC;
    cycle();
    repeat (8) cycle();
    #1;
    chk("D_addr0", qget(acc_log, 0), 32'hFFFF_FFFC);
    chk("D_addr1", qget(acc_log, 1), 32'h0000_0000);
    knobs(100, 0, 0, 0, 0, 0);
    do_reset();
    repeat (4) cycle();
    knobs(100, 0, 0, 0, 100, 0);
    cycle();
    clear_logs();
    knobs(100, 100, 0, 0, 100, 0);
    f_redir = 1; f_rpc = 32'h0000_2000;
    cycle();
    #1;
    chk("E_inst_valid_after", 32'(inst_valid), 32'd0);
    repeat (6) cycle();
    #1;
    chk("E_pc0", qget(out_log, 0), 32'h0000_2000);
    knobs(100, 0, 0, 0, 100, 0);
    do_reset();
    repeat (6) cycle();
    #1;
    chk("F_full_inst_valid", 32'(inst_valid), 32'd1);
    do_reset();
    clear_logs();
    knobs(100, 100, 0, 0, 100, 0);
    repeat (4) cycle();
    #1;
    chk("F_restart_addr", qget(acc_log, 0), RESET_PC);
    for (int s = 0; s < 40; s++) begin
      knobs($urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(60, 0),
            $urandom_range(3, 0), $urandom_range(100, 40), $urandom_range(20, 0));
      repeat (100) cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
